// File: rtl/icache_ctrl_pkg.sv
// Shared bus definitions for the instruction cache: memory bus commands,
// the memory tag width and the controller state encoding.
package icache_ctrl_pkg;

   localparam int MEM_TAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_command_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } icache_state_e;

   // Drop the byte offset so every address names a whole instruction word.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled.
// The cache is the slave; the fetch stage / memory model side is the master.
interface icache_ctrl_if
   import icache_ctrl_pkg::*;
();

   logic [31:0]          proc2Icache_addr;
   bus_command_e         proc2Icache_command;
   logic [31:0]          Icache2proc_data;
   logic                 Icache2proc_valid;

   logic [31:0]          proc2Imem_addr;
   bus_command_e         proc2Imem_command;
   logic [MEM_TAG_W-1:0] Imem2proc_response;
   logic [31:0]          Imem2proc_data;
   logic [MEM_TAG_W-1:0] Imem2proc_tag;

   modport master (
      output proc2Icache_addr, proc2Icache_command,
      output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
      input  Icache2proc_data, Icache2proc_valid,
      input  proc2Imem_addr, proc2Imem_command
   );

   modport slave (
      input  proc2Icache_addr, proc2Icache_command,
      input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
      output Icache2proc_data, Icache2proc_valid,
      output proc2Imem_addr, proc2Imem_command
   );

endinterface

// File: rtl/icache_ctrl_mem.sv
// Line storage for the direct-mapped instruction cache: valid bits, tags and
// instruction words. Combinational read port, one synchronous write port.
// Only the valid bits are reset; tag/data contents are meaningless until filled.
module icache_mem
   import icache_ctrl_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int IDX_W     = $clog2(NUM_LINES),
   parameter int TAG_W     = 32 - IDX_W - 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data
);

   logic [NUM_LINES-1:0] valid_reg;
   logic [NUM_LINES-1:0] line_we;
   logic [TAG_W-1:0]     tag_array  [NUM_LINES];
   logic [31:0]          data_array [NUM_LINES];

   // One write-enable per line, decoded from the write index.
   generate
      for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line_we
         assign line_we[gi] = wr_en && (wr_idx == IDX_W'(gi));
      end
   endgenerate

   // Valid bits: cleared by reset, set when their line is filled.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_reg | line_we;
      end
   end

   // Tag and data arrays: plain writes, no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_array[wr_idx]  <= wr_tag;
         data_array[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_reg[rd_idx];
   assign rd_tag   = tag_array[rd_idx];
   assign rd_data  = data_array[rd_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller. Hits are served in
// the same cycle; a miss issues a single LOAD to memory, retries until the
// memory accepts it, then waits for the matching tag and fills the line.
module icache_ctrl
   import icache_ctrl_pkg::*;
#(
   parameter int NUM_LINES = 32,
   parameter int IDX_W     = $clog2(NUM_LINES)
) (
   input logic          clk,
   input logic          rst,
   icache_ctrl_if.slave bus
);

   localparam int TAG_W = 32 - IDX_W - 2;

   icache_state_e        state_reg, state_next;
   logic [31:0]          addr_reg, addr_next;
   logic [MEM_TAG_W-1:0] req_tag_reg, req_tag_next;

   logic [31:0]      cur_word;
   logic [IDX_W-1:0] cur_idx;
   logic [TAG_W-1:0] cur_tag;
   logic [IDX_W-1:0] lat_idx;
   logic [TAG_W-1:0] lat_tag;

   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;

   logic is_load;
   logic hit;
   logic miss;
   logic fill;
   logic bypass;
   logic fill_en;

   assign cur_word = word_align(bus.proc2Icache_addr);
   assign cur_idx  = cur_word[IDX_W+1:2];
   assign cur_tag  = cur_word[31:IDX_W+2];
   assign lat_idx  = addr_reg[IDX_W+1:2];
   assign lat_tag  = addr_reg[31:IDX_W+2];

   icache_mem #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (cur_idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (fill_en),
      .wr_idx   (lat_idx),
      .wr_tag   (lat_tag),
      .wr_data  (bus.Imem2proc_data)
   );

   // Lookup and fill detection; a fill only counts while waiting on our tag.
   always_comb begin
      is_load = (bus.proc2Icache_command == BUS_LOAD);
      hit     = is_load && rd_valid && (rd_tag == cur_tag);
      miss    = is_load && !hit;
      fill    = (state_reg == ST_WAIT) && (bus.Imem2proc_tag != '0) &&
                (bus.Imem2proc_tag == req_tag_reg);
      bypass  = fill && is_load && (cur_word == addr_reg);
   end

   // Hit data from the array, or the returning word when it is the one asked for.
   always_comb begin
      bus.Icache2proc_valid = hit || bypass;
      bus.Icache2proc_data  = '0;
      if (hit) begin
         bus.Icache2proc_data = rd_data;
      end else if (bypass) begin
         bus.Icache2proc_data = bus.Imem2proc_data;
      end
   end

   // Miss FSM: next state, latched request and memory-side outputs.
   always_comb begin
      state_next             = state_reg;
      addr_next              = addr_reg;
      req_tag_next           = req_tag_reg;
      fill_en                = 1'b0;
      bus.proc2Imem_command  = BUS_NONE;
      bus.proc2Imem_addr     = '0;
      case (state_reg)
         ST_IDLE: begin
            if (miss) begin
               addr_next  = cur_word;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            bus.proc2Imem_command = BUS_LOAD;
            bus.proc2Imem_addr    = addr_reg;
            if (bus.Imem2proc_response != '0) begin
               req_tag_next = bus.Imem2proc_response;
               state_next   = ST_WAIT;
            end else if (cur_word != addr_reg) begin
               // Fetch moved on before acceptance: chase the new miss or give up.
               if (miss) begin
                  addr_next = cur_word;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            if (fill) begin
               fill_en    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, latched miss address and accepted request tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         addr_reg    <= '0;
         req_tag_reg <= '0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         req_tag_reg <= req_tag_next;
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// Testbench for icache_ctrl: directed scenarios followed by randomized fetch
// and memory traffic, every cycle checked against a line-level cache model.
module tb_icache_ctrl;
   import icache_ctrl_pkg::*;

   localparam int NL = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   icache_ctrl_if bus();

   icache_ctrl #(.NUM_LINES(NL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: which word address each line holds, and the miss in flight.
   bit          m_known = 1'b0;
   bit          m_req   = 1'b0;
   bit          m_wait  = 1'b0;
   logic [31:0] m_lat   = '0;
   logic [3:0]  m_want  = '0;
   bit          m_ok   [NL];
   logic [31:0] m_addr [NL];
   logic [31:0] m_data [NL];

   logic        obs_valid;
   logic [31:0] obs_data;
   logic [1:0]  obs_cmd;
   logic [31:0] obs_maddr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic cyc(input logic r, input logic [31:0] a, input bus_command_e c,
                      input logic [3:0] resp, input logic [3:0] tg, input logic [31:0] d);
      logic [31:0] wa;
      int          idx;
      int          lidx;
      logic        hitp, fillp, byp;
      logic        evalid;
      logic [31:0] edata;
      @(negedge clk);
      rst                    = r;
      bus.proc2Icache_addr   = a;
      bus.proc2Icache_command = c;
      bus.Imem2proc_response = resp;
      bus.Imem2proc_tag      = tg;
      bus.Imem2proc_data     = d;
      #1;
      obs_valid = bus.Icache2proc_valid;
      obs_data  = bus.Icache2proc_data;
      obs_cmd   = 2'(bus.proc2Imem_command);
      obs_maddr = bus.proc2Imem_addr;

      wa     = {a[31:2], 2'b00};
      idx    = int'((wa >> 2) % NL);
      lidx   = int'((m_lat >> 2) % NL);
      hitp   = (c == BUS_LOAD) && m_ok[idx] && (m_addr[idx] == wa);
      fillp  = m_wait && (tg != 4'h0) && (tg == m_want);
      byp    = fillp && (c == BUS_LOAD) && (wa == m_lat);
      evalid = hitp || byp;
      edata  = hitp ? m_data[idx] : (byp ? d : 32'h0);
      if (m_known) begin
         chk("m_valid", 32'(obs_valid), 32'(evalid));
         chk("m_data", obs_data, edata);
         chk("m_cmd", 32'(obs_cmd), m_req ? 32'(BUS_LOAD) : 32'(BUS_NONE));
         chk("m_maddr", obs_maddr, m_req ? m_lat : 32'h0);
      end

      @(posedge clk);
      if (r) begin
         m_known = 1'b1;
         m_req   = 1'b0;
         m_wait  = 1'b0;
         foreach (m_ok[i]) m_ok[i] = 1'b0;
         $display("txn reset t=%0t", $time);
      end else if (m_known) begin
         if (m_wait) begin
            if (fillp) begin
               m_ok[lidx]   = 1'b1;
               m_addr[lidx] = m_lat;
               m_data[lidx] = d;
               m_wait       = 1'b0;
               $display("txn fill addr=%h tag=%0d data=%h", m_lat, tg, d);
            end
         end else if (m_req) begin
            if (resp != 4'h0) begin
               m_want = resp;
               m_req  = 1'b0;
               m_wait = 1'b1;
            end else if (wa != m_lat) begin
               if (c == BUS_LOAD && !hitp) m_lat = wa;
               else m_req = 1'b0;
            end
         end else if (c == BUS_LOAD && !hitp) begin
            m_lat = wa;
            m_req = 1'b1;
         end
      end
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] a;
      int          idx;
      case ($urandom_range(0, 3))
         0:       idx = 0;
         1:       idx = 1;
         2:       idx = 16;
         default: idx = 31;
      endcase
      a = (32'($urandom_range(0, 2)) << 7) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      return a;
   endfunction

   initial begin
      logic [31:0]  ra;
      bus_command_e rc;
      logic [3:0]   rresp, rtag;
      logic         rr;

      bus.proc2Icache_addr    = '0;
      bus.proc2Icache_command = BUS_NONE;
      bus.Imem2proc_response  = '0;
      bus.Imem2proc_tag       = '0;
      bus.Imem2proc_data      = '0;

      cyc(1, 32'h0, BUS_NONE, 0, 0, 0);
      cyc(1, 32'h0, BUS_NONE, 0, 0, 0);

      // 1: cold miss, fill with bypass, then a hit
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("rst_valid", 32'(obs_valid), 32'h0);
      chk("rst_cmd", 32'(obs_cmd), 32'(BUS_NONE));
      cyc(0, 32'h40, BUS_LOAD, 3, 0, 0);
      chk("t1_req_cmd", 32'(obs_cmd), 32'(BUS_LOAD));
      chk("t1_req_addr", obs_maddr, 32'h40);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("t1_wait_cmd", 32'(obs_cmd), 32'(BUS_NONE));
      cyc(0, 32'h40, BUS_LOAD, 0, 3, 32'hDEADBEEF);
      chk("t1_byp_valid", 32'(obs_valid), 32'h1);
      chk("t1_byp_data", obs_data, 32'hDEADBEEF);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("t1_hit_valid", 32'(obs_valid), 32'h1);
      chk("t1_hit_data", obs_data, 32'hDEADBEEF);
      chk("t1_hit_cmd", 32'(obs_cmd), 32'(BUS_NONE));
      $display("txn test1 cold miss done");

      // 2: two rejected requests, accepted on the third
      cyc(1, 32'h0, BUS_NONE, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("t2_idle_cmd", 32'(obs_cmd), 32'(BUS_NONE));
      for (int k = 0; k < 3; k++) begin
         cyc(0, 32'h40, BUS_LOAD, (k == 2) ? 4'd5 : 4'd0, 0, 0);
         chk("t2_req_cmd", 32'(obs_cmd), 32'(BUS_LOAD));
         chk("t2_req_addr", obs_maddr, 32'h40);
      end
      cyc(0, 32'h40, BUS_LOAD, 0, 5, 32'h11112222);
      chk("t2_fill_valid", 32'(obs_valid), 32'h1);
      chk("t2_fill_data", obs_data, 32'h11112222);
      $display("txn test2 retries done");

      // 3: conflicting line replaces 0x40, which must then miss
      cyc(0, 32'hC0, BUS_LOAD, 0, 0, 0);
      chk("t3_conf_valid", 32'(obs_valid), 32'h0);
      cyc(0, 32'hC0, BUS_LOAD, 1, 0, 0);
      chk("t3_conf_addr", obs_maddr, 32'hC0);
      cyc(0, 32'hC0, BUS_LOAD, 0, 1, 32'hBBBB00C0);
      chk("t3_conf_data", obs_data, 32'hBBBB00C0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("t3_stale_valid", 32'(obs_valid), 32'h0);
      chk("t3_stale_data", obs_data, 32'h0);
      cyc(0, 32'h40, BUS_LOAD, 2, 0, 0);
      chk("t3_reload_cmd", 32'(obs_cmd), 32'(BUS_LOAD));
      chk("t3_reload_addr", obs_maddr, 32'h40);
      cyc(0, 32'h40, BUS_LOAD, 0, 2, 32'h11112222);
      $display("txn test3 conflict done");

      // 4: fetch address moves while waiting on the fill
      cyc(1, 32'h0, BUS_NONE, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 2, 0, 0);
      cyc(0, 32'h80, BUS_LOAD, 0, 0, 0);
      chk("t4_wait_valid", 32'(obs_valid), 32'h0);
      cyc(0, 32'h80, BUS_LOAD, 0, 2, 32'hCAFE0040);
      chk("t4_fill_valid", 32'(obs_valid), 32'h0);
      cyc(0, 32'h80, BUS_LOAD, 0, 0, 0);
      chk("t4_idle_cmd", 32'(obs_cmd), 32'(BUS_NONE));
      cyc(0, 32'h80, BUS_LOAD, 6, 0, 0);
      chk("t4_req_cmd", 32'(obs_cmd), 32'(BUS_LOAD));
      chk("t4_req_addr", obs_maddr, 32'h80);
      cyc(0, 32'h80, BUS_LOAD, 0, 6, 32'hCAFE0080);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("t4_old_hit", 32'(obs_valid), 32'h1);
      chk("t4_old_data", obs_data, 32'hCAFE0040);
      $display("txn test4 addr change done");

      // 5: a foreign tag is ignored while waiting
      cyc(1, 32'h0, BUS_NONE, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 4, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 0, 2, 32'h00001234);
      chk("t5_wrong_valid", 32'(obs_valid), 32'h0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("t5_still_valid", 32'(obs_valid), 32'h0);
      chk("t5_still_cmd", 32'(obs_cmd), 32'(BUS_NONE));
      cyc(0, 32'h40, BUS_LOAD, 0, 4, 32'h44440040);
      chk("t5_fill_valid", 32'(obs_valid), 32'h1);
      chk("t5_fill_data", obs_data, 32'h44440040);
      $display("txn test5 wrong tag done");

      // 6: reset abandons an outstanding miss
      cyc(1, 32'h0, BUS_NONE, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 7, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      cyc(1, 32'h40, BUS_LOAD, 0, 0, 0);
      cyc(0, 32'h40, BUS_LOAD, 0, 7, 32'h77770040);
      chk("t6_cmd", 32'(obs_cmd), 32'(BUS_NONE));
      chk("t6_valid", 32'(obs_valid), 32'h0);
      cyc(0, 32'h40, BUS_LOAD, 0, 0, 0);
      chk("t6_remiss_cmd", 32'(obs_cmd), 32'(BUS_LOAD));
      chk("t6_remiss_addr", obs_maddr, 32'h40);
      chk("t6_remiss_valid", 32'(obs_valid), 32'h0);
      $display("txn test6 reset mid-miss done");

      // Randomized traffic against the model
      ra = pick_addr();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) ra = pick_addr();
         rc    = ($urandom_range(0, 4) != 0) ? BUS_LOAD : BUS_NONE;
         rresp = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         if (m_wait && $urandom_range(0, 2) == 0) begin
            rtag = m_want;
         end else begin
            rtag = 4'($urandom_range(0, 15));
            if (m_wait && rtag == m_want) rtag = 4'h0;
         end
         rr = ($urandom_range(0, 199) == 0);
         cyc(rr, ra, rc, rresp, rtag, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the processor's fetch port (PC address and IM command) and the tagged instruction memory model.
- Serves hits combinationally in the same cycle.
- On a miss, issues one LOAD to memory, holds it until memory accepts it (non-zero response), then waits for the matching tag and fills the line.
- At most one outstanding memory request.

Parameters:
NUM_LINES, 32, number of one-word cache lines; power of two
IDX_W, $clog2(NUM_LINES), index width; index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
proc2Icache_addr  input  32  fetch byte address from IF stage
proc2Icache_command  input  2  BUS_NONE/BUS_LOAD; only BUS_LOAD triggers lookup/miss
Icache2proc_data  output  32  instruction word; 0 when valid low
Icache2proc_valid  output  1  instruction for current address available this cycle
proc2Imem_addr  output  32  word-aligned miss address; 0 when command NONE
proc2Imem_command  output  2  BUS_LOAD while requesting, else BUS_NONE
Imem2proc_response  input  4  non-zero = request accepted, value is its tag
Imem2proc_data  input  32  returned data, qualified by Imem2proc_tag
Imem2proc_tag  input  4  non-zero tag of returned data

Behaviour:
- Reset (sync, rst high at posedge):
  - State goes to IDLE and all valid bits clear.
  - Stored request tag is 0; proc2Imem_command is NONE; Icache2proc_valid is 0.
  - Data and tag arrays are not reset.
- Hit is combinational: command==LOAD and valid[idx] and tag_array[idx]==addr tag. Then valid=1 and data=data_array[idx], in any state.
- States:
  - IDLE: on a LOAD miss, latch the word-aligned address, go to REQ. No memory command in the IDLE cycle.
  - REQ: drive LOAD with the latched address.
    - Response==0: stay and retry next cycle, same address.
    - Response!=0: store it as req_tag, go to WAIT.
    - If the processor address changes to a different word while in REQ and not yet accepted, relatch the new address. This applies only if the new address is itself a LOAD miss; otherwise return to IDLE.
  - WAIT: command NONE.
    - When Imem2proc_tag==req_tag (non-zero), write data_array/tag_array/valid for the latched line and go to IDLE.
    - Tags that do not match are ignored.
- Fill bypass: in the fill cycle, if the current LOAD address equals the latched address, assert valid=1 with data=Imem2proc_data the same cycle.
- Address change during WAIT:
  - The outstanding fill still completes into the old line.
  - No valid is given for the new address until its own hit or fill.
  - The new miss is recognised in IDLE the cycle after the fill, so its REQ begins two cycles after the fill edge.
- Conflict: a fill overwrites the indexed line unconditionally; no replacement policy is needed.
- Reset mid-miss: the request is abandoned and a later arrival of the old tag is ignored, because state is IDLE.
- Response and tag in the same cycle: only the response is meaningful in REQ; tags are not examined until WAIT.

Decomposition:
- BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2 and the 4-bit mem tag width come from the shared sys_defs definitions. No new local constants are defined.
- Sub-module icache_mem holds the valid, tag and data arrays. It has one combinational read port (index → valid/tag/data) and one synchronous write port (en, index, tag, data), and clears valid on rst.
- icache_ctrl holds the FSM, latched address, req_tag and the bypass mux.

Test Plan:
1. Cold miss: after rst, addr 0x40 LOAD.
   - Next cycle: proc2Imem_command=LOAD, addr=0x40.
   - Response=3 → WAIT.
   - Tag 3 with data 0xDEADBEEF arrives → valid=1, data=0xDEADBEEF that cycle.
   - Next cycle: hit with command NONE.
2. Rejected requests: response=0 for 2 cycles → LOAD at 0x40 held 3 cycles. Response=5 on the third → WAIT; tag 5 fills.
3. Conflict: fill 0x40 (data A), then 0xC0 (same index 16, data B). Returning to 0x40 → miss, new LOAD at 0x40, no stale valid with B.
4. Addr change in WAIT: miss 0x40 accepted (tag 2), addr switches to 0x80.
   - Tag 2 arrives → no valid.
   - 0x40 is later a hit.
   - LOAD 0x80 is issued two cycles after the fill edge.
5. Wrong tag: waiting on tag 4, tag 2 with data 0x1234 arrives → ignored, no fill, still WAIT. Tag 4 then fills.
6. Reset mid-WAIT: rst during WAIT → next cycle command NONE, valid 0. Tag later arrives → no fill; addr 0x40 misses again.
